adbg_tap_sync: RTL and testbench
================================

# adbg_tap_sync

Oversampled IEEE 1149.1 JTAG TAP controller for the advanced debug interface. JTAG pins are treated as plain data inputs sampled on the system clock, so there is no TCK clock domain. The block runs the 16-state TAP FSM, holds a 4-bit instruction register, an IDCODE register and a bypass bit, and drives TAP-state and chain-select strobes to the debug, boundary-scan and MBIST sub-chains. It sits between the JTAG pads (or a simulation JTAG driver) and the debug module.

## Interface
- IDCODE_VALUE, 32'h149511c3, value loaded into the IDCODE register at Capture-DR.
- SYNC_STAGES, 2, flops per pad input synchronizer (minimum 2).
- clk  in  1  system clock; frequency must be ≥ 4× TCK.
- rst  in  1  reset; one clock, reset is synchronous and active-high.
- tck_pad_i, tms_pad_i, tdi_pad_i  in  1 each  JTAG pins, asynchronous to clk.
- trstn_pad_i  in  1  JTAG TRST, active-low, synchronized; low forces Test-Logic-Reset.
- tdo_pad_o  out  1  TDO data; tdo_padoe_o  out  1  TDO output enable.
- test_mode_i  in  1  DFT reserved; no functional effect.
- test_logic_reset_o, run_test_idle_o, shift_dr_o, pause_dr_o, update_dr_o, capture_dr_o  out  1 each  high while the FSM is in that state.
- extest_select_o, sample_preload_select_o, mbist_select_o, debug_select_o  out  1 each  decoded from the latched IR.
- tdi_o  out  1  synchronized TDI forwarded to the sub-chains.
- debug_tdo_i, bs_chain_tdo_i, mbist_tdo_i  in  1 each  serial returns from the sub-chains.

## Operation
- Each pad input passes through SYNC_STAGES flops. A TCK rise or fall is the cycle in which the synchronized TCK differs from its one-cycle-delayed copy.
- On a TCK rise, the FSM follows the standard 1149.1 transitions using synchronized TMS:
  - States: TLR, RTI, SelDR, CapDR, ShDR, Ex1DR, PauDR, Ex2DR, UpdDR, SelIR, CapIR, ShIR, Ex1IR, PauIR, Ex2IR, UpdIR.
  - Five consecutive TMS=1 rises reach TLR from any state.
- Also on a TCK rise:
  - CapIR: IR shift register ← 4'b0101.
  - ShIR: IR shift register shifts right, TDI enters the MSB.
  - UpdIR: latched IR ← IR shift register.
  - CapDR: IDCODE register ← IDCODE_VALUE; bypass bit ← 0.
  - ShDR: IDCODE register shifts right with TDI into bit 31; bypass bit ← TDI.
- Opcodes: EXTEST 4'b0000, SAMPLE_PRELOAD 4'b0001, IDCODE 4'b0010, DEBUG 4'b1000, MBIST 4'b1001, BYPASS 4'b1111. Any other code behaves as BYPASS.
- In TLR, the latched IR is forced to IDCODE.
- Select outputs are registered decodes of the latched IR. Exactly one select is high, or none for IDCODE/BYPASS. sample_preload_select_o covers SAMPLE_PRELOAD only.
- TDO mux source, by state and latched IR:
  - ShIR: IR shift register bit 0.
  - ShDR with IDCODE: IDCODE register bit 0.
  - ShDR with DEBUG: debug_tdo_i.
  - ShDR with EXTEST or SAMPLE_PRELOAD: bs_chain_tdo_i.
  - ShDR with MBIST: mbist_tdo_i.
  - Otherwise: bypass bit.
- tdo_pad_o and tdo_padoe_o are registered on a TCK fall. tdo_padoe_o is 1 iff the FSM is in ShIR or ShDR at that fall.
- tdi_o is the synchronized TDI, unregistered beyond the synchronizer.
- If synchronized trstn is low, the FSM is held in TLR every cycle, with the same effect as TLR entry.

## Timing
- Reset (rst=1 at a clk edge) forces:
  - FSM to TLR; latched IR to IDCODE; IR shift register to 0; IDCODE register to IDCODE_VALUE; bypass bit to 0.
  - Synchronizers to 0 (so no spurious edge is seen after reset).
  - Outputs: test_logic_reset_o=1, all other state strobes and selects 0, tdo_pad_o=0, tdo_padoe_o=0.
- Latency from a pad TCK edge to the FSM/register update is SYNC_STAGES+1 clk cycles. State outputs are valid in the cycle after the state register updates.
- A TCK pulse (high or low) shorter than 2 clk cycles is unsupported.
- When a rise is detected, the TMS/TDI values used are the synchronized values in that same cycle.
- rst asserted mid-shift aborts immediately; the next TCK activity starts from TLR.
- rst takes priority over trstn and over edge events in the same cycle.

## Structure
- Package adbg_tap_pkg holds the 16-value state enum, IR_LENGTH=4, the opcode localparams, and the IR capture constant 4'b0101.
- One sub-module, adbg_tap_sync_in: a parameterized multi-stage synchronizer with rise/fall edge detect. Instantiate it for TCK; use plain synchronizer instances for TMS, TDI and TRSTn.

## Test plan
- Reset then 5 TCK pulses with TMS=1 -> test_logic_reset_o=1, all selects 0, tdo_padoe_o=0.
- TLR→RTI→SelDR→CapDR→ShDR, shift 32 bits -> TDO returns 32'h149511c3 LSB-first with tdo_padoe_o=1; capture_dr_o pulses for one TCK period.
- Shift-IR 4'b1000, then UpdIR -> debug_select_o=1; in ShDR, tdo_pad_o follows debug_tdo_i, and tdi_o follows tdi_pad_i.
- Load IR 4'b1111, then shift pattern 1,0,1,1 through DR -> same pattern on TDO delayed by 1 TCK.
- Shift-IR of 4 bits -> the first 4 TDO bits are 1,0,1,0 (capture value 4'b0101); loading 4'b0001 sets sample_preload_select_o, loading 4'b1001 sets mbist_select_o.
- trstn_pad_i low for 4 clk during ShDR, or rst mid-shift -> TLR, latched IR=IDCODE, tdo_padoe_o=0 by the next TCK fall.

Source files
------------

// File: rtl/adbg_tap_pkg.sv
// adbg_tap_pkg: TAP state encoding, IR opcodes and register widths shared by the TAP blocks.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package adbg_tap_pkg;

  localparam int IR_LENGTH     = 4;
  localparam int IDCODE_LENGTH = 32;

  // The 16 IEEE 1149.1 TAP controller states.
  typedef enum logic [3:0] {
    TAP_TLR,
    TAP_RTI,
    TAP_SEL_DR,
    TAP_CAP_DR,
    TAP_SH_DR,
    TAP_EX1_DR,
    TAP_PAU_DR,
    TAP_EX2_DR,
    TAP_UPD_DR,
    TAP_SEL_IR,
    TAP_CAP_IR,
    TAP_SH_IR,
    TAP_EX1_IR,
    TAP_PAU_IR,
    TAP_EX2_IR,
    TAP_UPD_IR
  } tap_state_e;

  typedef logic [IR_LENGTH-1:0] ir_t;

  localparam ir_t IR_EXTEST         = 4'b0000;
  localparam ir_t IR_SAMPLE_PRELOAD = 4'b0001;
  localparam ir_t IR_IDCODE         = 4'b0010;
  localparam ir_t IR_DEBUG          = 4'b1000;
  localparam ir_t IR_MBIST          = 4'b1001;
  localparam ir_t IR_BYPASS         = 4'b1111;

  // Value captured into the IR shift register; its 01 tail is what 1149.1 requires.
  localparam ir_t IR_CAPTURE = 4'b0101;

  // True in the two states that drive TDO.
  function automatic logic is_shift_state(tap_state_e s);
    return (s == TAP_SH_DR) || (s == TAP_SH_IR);
  endfunction

endpackage

// File: rtl/adbg_tap_sync_in.sv
// adbg_tap_sync_in: multi-stage pad synchronizer with optional rise/fall strobes.
// Latency: STAGES clk to dout; rise/fall are combinational off dout and its delayed copy.
// Backpressure: none; pads are sampled every clk.
module adbg_tap_sync_in #(
  parameter int STAGES = 2,
  parameter int WIDTH  = 1,
  parameter bit EDGES  = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  // STAGES must be at least 2; element 0 takes the raw pad.
  logic [STAGES-1:0][WIDTH-1:0] sync_q;

  // Shift the pad value through the synchronizer chain; clear on reset so no edge follows.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], din};
    end
  end

  assign dout = sync_q[STAGES-1];

  generate
    if (EDGES) begin : g_edge
      logic [WIDTH-1:0] dly_q;

      // One-cycle-delayed copy of the synchronized value for edge detection.
      always_ff @(posedge clk) begin
        if (rst) begin
          dly_q <= '0;
        end else begin
          dly_q <= dout;
        end
      end

      assign rise = dout & ~dly_q;
      assign fall = ~dout & dly_q;
    end else begin : g_no_edge
      assign rise = '0;
      assign fall = '0;
    end
  endgenerate

endmodule

// File: rtl/adbg_tap_sync.sv
// adbg_tap_sync: oversampled JTAG TAP (FSM, 4-bit IR, IDCODE, bypass) with sub-chain selects.
// Latency: pad TCK edge to FSM/register update SYNC_STAGES+1 clk; state strobes one clk later.
// Backpressure: none; clk must run at least 4x TCK and TCK phases last at least 2 clk.
module adbg_tap_sync
  import adbg_tap_pkg::*;
#(
  parameter logic [31:0] IDCODE_VALUE = 32'h149511c3,
  parameter int          SYNC_STAGES  = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic tck_pad_i,
  input  logic tms_pad_i,
  input  logic tdi_pad_i,
  input  logic trstn_pad_i,
  output logic tdo_pad_o,
  output logic tdo_padoe_o,
  input  logic test_mode_i,
  output logic test_logic_reset_o,
  output logic run_test_idle_o,
  output logic shift_dr_o,
  output logic pause_dr_o,
  output logic update_dr_o,
  output logic capture_dr_o,
  output logic extest_select_o,
  output logic sample_preload_select_o,
  output logic mbist_select_o,
  output logic debug_select_o,
  output logic tdi_o,
  input  logic debug_tdo_i,
  input  logic bs_chain_tdo_i,
  input  logic mbist_tdo_i
);

  logic       tck_s;
  logic       tck_rise;
  logic       tck_fall;
  logic [2:0] pin_s;
  logic [2:0] pin_rise_unused;
  logic [2:0] pin_fall_unused;
  logic       tms_s;
  logic       tdi_s;
  logic       trstn_s;

  tap_state_e                 state;
  tap_state_e                 state_nxt;
  ir_t                        ir_sr;
  ir_t                        ir_q;
  logic [IDCODE_LENGTH-1:0]   idcode_sr;
  logic                       bypass_q;
  logic                       shift_en;
  logic                       tdo_mux;

  adbg_tap_sync_in #(
    .STAGES (SYNC_STAGES),
    .WIDTH  (1),
    .EDGES  (1'b1)
  ) u_tck_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (tck_pad_i),
    .dout (tck_s),
    .rise (tck_rise),
    .fall (tck_fall)
  );

  adbg_tap_sync_in #(
    .STAGES (SYNC_STAGES),
    .WIDTH  (3),
    .EDGES  (1'b0)
  ) u_pin_sync (
    .clk  (clk),
    .rst  (rst),
    .din  ({trstn_pad_i, tdi_pad_i, tms_pad_i}),
    .dout (pin_s),
    .rise (pin_rise_unused),
    .fall (pin_fall_unused)
  );

  assign tms_s   = pin_s[0];
  assign tdi_s   = pin_s[1];
  assign trstn_s = pin_s[2];
  assign tdi_o   = tdi_s;

  // test_mode_i is a DFT hook with no functional effect; the level of tck_s is only used via its edges.
  logic unused_ok;
  assign unused_ok = ^{test_mode_i, tck_s, pin_rise_unused, pin_fall_unused};

  // Register updates happen only on a TCK rise while TRST is released.
  assign shift_en = tck_rise & trstn_s;

  // TAP state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= TAP_TLR;
    end else begin
      state <= state_nxt;
    end
  end

  // Standard 1149.1 next-state on a TCK rise; TRST holds Test-Logic-Reset.
  always_comb begin
    state_nxt = state;
    if (!trstn_s) begin
      state_nxt = TAP_TLR;
    end else if (tck_rise) begin
      case (state)
        TAP_TLR:    state_nxt = tms_s ? TAP_TLR    : TAP_RTI;
        TAP_RTI:    state_nxt = tms_s ? TAP_SEL_DR : TAP_RTI;
        TAP_SEL_DR: state_nxt = tms_s ? TAP_SEL_IR : TAP_CAP_DR;
        TAP_CAP_DR: state_nxt = tms_s ? TAP_EX1_DR : TAP_SH_DR;
        TAP_SH_DR:  state_nxt = tms_s ? TAP_EX1_DR : TAP_SH_DR;
        TAP_EX1_DR: state_nxt = tms_s ? TAP_UPD_DR : TAP_PAU_DR;
        TAP_PAU_DR: state_nxt = tms_s ? TAP_EX2_DR : TAP_PAU_DR;
        TAP_EX2_DR: state_nxt = tms_s ? TAP_UPD_DR : TAP_SH_DR;
        TAP_UPD_DR: state_nxt = tms_s ? TAP_SEL_DR : TAP_RTI;
        TAP_SEL_IR: state_nxt = tms_s ? TAP_TLR    : TAP_CAP_IR;
        TAP_CAP_IR: state_nxt = tms_s ? TAP_EX1_IR : TAP_SH_IR;
        TAP_SH_IR:  state_nxt = tms_s ? TAP_EX1_IR : TAP_SH_IR;
        TAP_EX1_IR: state_nxt = tms_s ? TAP_UPD_IR : TAP_PAU_IR;
        TAP_PAU_IR: state_nxt = tms_s ? TAP_EX2_IR : TAP_PAU_IR;
        TAP_EX2_IR: state_nxt = tms_s ? TAP_UPD_IR : TAP_SH_IR;
        TAP_UPD_IR: state_nxt = tms_s ? TAP_SEL_DR : TAP_RTI;
        default:    state_nxt = TAP_TLR;
      endcase
    end
  end

  // Instruction shift register and latched IR; TLR (or TRST) pins the IR to IDCODE.
  always_ff @(posedge clk) begin
    if (rst) begin
      ir_sr <= '0;
      ir_q  <= IR_IDCODE;
    end else begin
      if (!trstn_s || state == TAP_TLR) begin
        ir_q <= IR_IDCODE;
      end else if (shift_en && state == TAP_UPD_IR) begin
        ir_q <= ir_sr;
      end

      if (shift_en) begin
        if (state == TAP_CAP_IR) begin
          ir_sr <= IR_CAPTURE;
        end else if (state == TAP_SH_IR) begin
          ir_sr <= {tdi_s, ir_sr[IR_LENGTH-1:1]};
        end
      end
    end
  end

  // IDCODE and bypass data registers; both capture/shift regardless of the selected IR.
  always_ff @(posedge clk) begin
    if (rst) begin
      idcode_sr <= IDCODE_VALUE;
      bypass_q  <= 1'b0;
    end else if (shift_en) begin
      if (state == TAP_CAP_DR) begin
        idcode_sr <= IDCODE_VALUE;
        bypass_q  <= 1'b0;
      end else if (state == TAP_SH_DR) begin
        idcode_sr <= {tdi_s, idcode_sr[IDCODE_LENGTH-1:1]};
        bypass_q  <= tdi_s;
      end
    end
  end

  // Registered state strobes, valid the cycle after the state register moves.
  always_ff @(posedge clk) begin
    if (rst) begin
      test_logic_reset_o <= 1'b1;
      run_test_idle_o    <= 1'b0;
      shift_dr_o         <= 1'b0;
      pause_dr_o         <= 1'b0;
      update_dr_o        <= 1'b0;
      capture_dr_o       <= 1'b0;
    end else begin
      test_logic_reset_o <= (state == TAP_TLR);
      run_test_idle_o    <= (state == TAP_RTI);
      shift_dr_o         <= (state == TAP_SH_DR);
      pause_dr_o         <= (state == TAP_PAU_DR);
      update_dr_o        <= (state == TAP_UPD_DR);
      capture_dr_o       <= (state == TAP_CAP_DR);
    end
  end

  // Registered chain selects; IDCODE, BYPASS and unknown opcodes select nothing.
  always_ff @(posedge clk) begin
    if (rst) begin
      extest_select_o         <= 1'b0;
      sample_preload_select_o <= 1'b0;
      mbist_select_o          <= 1'b0;
      debug_select_o          <= 1'b0;
    end else begin
      extest_select_o         <= (ir_q == IR_EXTEST);
      sample_preload_select_o <= (ir_q == IR_SAMPLE_PRELOAD);
      mbist_select_o          <= (ir_q == IR_MBIST);
      debug_select_o          <= (ir_q == IR_DEBUG);
    end
  end

  // TDO source: IR LSB in Shift-IR, the selected data register in Shift-DR, else bypass.
  always_comb begin
    tdo_mux = bypass_q;
    if (state == TAP_SH_IR) begin
      tdo_mux = ir_sr[0];
    end else if (state == TAP_SH_DR) begin
      case (ir_q)
        IR_IDCODE:                    tdo_mux = idcode_sr[0];
        IR_DEBUG:                     tdo_mux = debug_tdo_i;
        IR_EXTEST, IR_SAMPLE_PRELOAD: tdo_mux = bs_chain_tdo_i;
        IR_MBIST:                     tdo_mux = mbist_tdo_i;
        default:                      tdo_mux = bypass_q;
      endcase
    end
  end

  // TDO and its enable change on the TCK fall, half a TCK ahead of the next sampling rise.
  always_ff @(posedge clk) begin
    if (rst) begin
      tdo_pad_o   <= 1'b0;
      tdo_padoe_o <= 1'b0;
    end else if (tck_fall) begin
      tdo_pad_o   <= tdo_mux;
      tdo_padoe_o <= is_shift_state(state);
    end
  end

endmodule

// File: tb/tb_adbg_tap_sync.sv
// tb_adbg_tap_sync: randomized and directed JTAG traffic against a queue-based reference model.
// Latency: expectations are sampled 3 clk after each pad TCK fall.
// Backpressure: none; the bench paces TCK at 8 clk per period.
module tb_adbg_tap_sync;

  localparam logic [31:0] IDC  = 32'h149511c3;
  localparam int          HALF = 4;

  // Reference-model state numbering (independent of the RTL).
  localparam int S_TLR = 0,  S_RTI = 1,  S_SELDR = 2,  S_CAPDR = 3,
                 S_SHDR = 4, S_EX1DR = 5, S_PAUDR = 6, S_EX2DR = 7,
                 S_UPDDR = 8, S_SELIR = 9, S_CAPIR = 10, S_SHIR = 11,
                 S_EX1IR = 12, S_PAUIR = 13, S_EX2IR = 14, S_UPDIR = 15;

  // 1149.1 transition table: next state for TMS=0 and TMS=1.
  int go0 [16] = '{S_RTI, S_RTI, S_CAPDR, S_SHDR, S_SHDR, S_PAUDR, S_PAUDR, S_SHDR,
                   S_RTI, S_CAPIR, S_SHIR, S_SHIR, S_PAUIR, S_PAUIR, S_SHIR, S_RTI};
  int go1 [16] = '{S_TLR, S_SELDR, S_SELIR, S_EX1DR, S_EX1DR, S_UPDDR, S_EX2DR, S_UPDDR,
                   S_SELDR, S_TLR, S_EX1IR, S_EX1IR, S_UPDIR, S_EX2IR, S_UPDIR, S_SELDR};

  typedef struct packed {
    logic       tdo;
    logic       oe;
    logic [5:0] strb;
    logic [3:0] sel;
    logic       tdi;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tck = 1'b0, tms = 1'b1, tdi = 1'b0, trstn = 1'b1, test_mode = 1'b0;
  logic dbg_tdo = 1'b0, bs_tdo = 1'b0, mb_tdo = 1'b0;

  logic tdo_pad_o, tdo_padoe_o;
  logic test_logic_reset_o, run_test_idle_o, shift_dr_o, pause_dr_o, update_dr_o, capture_dr_o;
  logic extest_select_o, sample_preload_select_o, mbist_select_o, debug_select_o, tdi_o;

  int n_chk = 0;
  int n_fail = 0;

  int         m_st;
  logic [3:0] m_irsr, m_ir;
  logic [31:0] m_id;
  logic       m_byp;

  exp_t q[$];
  logic obs[$];
  exp_t mon_e;

  always #5 clk = ~clk;

  adbg_tap_sync dut (
    .clk                     (clk),
    .rst                     (rst),
    .tck_pad_i               (tck),
    .tms_pad_i               (tms),
    .tdi_pad_i               (tdi),
    .trstn_pad_i             (trstn),
    .tdo_pad_o               (tdo_pad_o),
    .tdo_padoe_o             (tdo_padoe_o),
    .test_mode_i             (test_mode),
    .test_logic_reset_o      (test_logic_reset_o),
    .run_test_idle_o         (run_test_idle_o),
    .shift_dr_o              (shift_dr_o),
    .pause_dr_o              (pause_dr_o),
    .update_dr_o             (update_dr_o),
    .capture_dr_o            (capture_dr_o),
    .extest_select_o         (extest_select_o),
    .sample_preload_select_o (sample_preload_select_o),
    .mbist_select_o          (mbist_select_o),
    .debug_select_o          (debug_select_o),
    .tdi_o                   (tdi_o),
    .debug_tdo_i             (dbg_tdo),
    .bs_chain_tdo_i          (bs_tdo),
    .mbist_tdo_i             (mb_tdo)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_chk++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp_v);
    end
  endtask

  function automatic logic [5:0] dut_strb();
    return {test_logic_reset_o, run_test_idle_o, shift_dr_o, pause_dr_o, update_dr_o, capture_dr_o};
  endfunction

  function automatic logic [3:0] dut_sel();
    return {extest_select_o, sample_preload_select_o, mbist_select_o, debug_select_o};
  endfunction

  task automatic model_reset();
    m_st   = S_TLR;
    m_ir   = 4'b0010;
    m_irsr = 4'b0000;
    m_id   = IDC;
    m_byp  = 1'b0;
  endtask

  // Apply one TCK rise to the model using the pad TMS/TDI just driven.
  task automatic model_rise();
    if (m_st == S_CAPIR) m_irsr = 4'b0101;
    if (m_st == S_SHIR)  m_irsr = {tdi, m_irsr[3:1]};
    if (m_st == S_UPDIR) m_ir   = m_irsr;
    if (m_st == S_CAPDR) begin
      m_id  = IDC;
      m_byp = 1'b0;
    end
    if (m_st == S_SHDR) begin
      m_id  = {tdi, m_id[31:1]};
      m_byp = tdi;
    end
    m_st = tms ? go1[m_st] : go0[m_st];
    if (m_st == S_TLR) m_ir = 4'b0010;
  endtask

  // Expected pin picture after a TCK fall.
  function automatic exp_t model_expect();
    exp_t e;
    e.oe  = (m_st == S_SHIR) || (m_st == S_SHDR);
    e.tdo = m_byp;
    if (m_st == S_SHIR) begin
      e.tdo = m_irsr[0];
    end else if (m_st == S_SHDR) begin
      if (m_ir == 4'b0010)                        e.tdo = m_id[0];
      else if (m_ir == 4'b1000)                   e.tdo = dbg_tdo;
      else if (m_ir == 4'b0000 || m_ir == 4'b0001) e.tdo = bs_tdo;
      else if (m_ir == 4'b1001)                   e.tdo = mb_tdo;
    end
    e.strb = {m_st == S_TLR, m_st == S_RTI, m_st == S_SHDR, m_st == S_PAUDR,
              m_st == S_UPDDR, m_st == S_CAPDR};
    e.sel  = {m_ir == 4'b0000, m_ir == 4'b0001, m_ir == 4'b1001, m_ir == 4'b1000};
    e.tdi  = tdi;
    return e;
  endfunction

  task automatic tck_cycle(input logic t, input logic d);
    @(negedge clk);
    tms     = t;
    tdi     = d;
    dbg_tdo = ($urandom & 1) != 0;
    bs_tdo  = ($urandom & 1) != 0;
    mb_tdo  = ($urandom & 1) != 0;
    tck     = 1'b1;
    model_rise();
    repeat (HALF) @(negedge clk);
    tck = 1'b0;
    q.push_back(model_expect());
    repeat (HALF - 1) @(negedge clk);
  endtask

  // From RTI: load an opcode (LSB first) and return to RTI.
  task automatic shift_ir(input logic [3:0] op);
    tck_cycle(1'b1, 1'b0);
    tck_cycle(1'b1, 1'b0);
    tck_cycle(1'b0, 1'b0);
    tck_cycle(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) tck_cycle(i == 3, op[i]);
    tck_cycle(1'b1, 1'b0);
    tck_cycle(1'b0, 1'b0);
  endtask

  // From RTI: shift n DR bits (LSB first) and return to RTI.
  task automatic shift_dr(input int n, input logic [63:0] bits);
    tck_cycle(1'b1, 1'b0);
    tck_cycle(1'b0, 1'b0);
    tck_cycle(1'b0, 1'b0);
    for (int i = 0; i < n; i++) tck_cycle(i == n - 1, bits[i]);
    tck_cycle(1'b1, 1'b0);
    tck_cycle(1'b0, 1'b0);
  endtask

  task automatic do_rst();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    chk("rst_strobes", 32'(dut_strb()), 32'h20);
    chk("rst_selects", 32'(dut_sel()), 32'h0);
    chk("rst_tdo", 32'(tdo_pad_o), 32'h0);
    chk("rst_tdo_oe", 32'(tdo_padoe_o), 32'h0);
    repeat (6) @(negedge clk);
  endtask

  task automatic do_trst();
    @(negedge clk);
    trstn = 1'b0;
    repeat (4) @(negedge clk);
    trstn = 1'b1;
    m_st = S_TLR;
    m_ir = 4'b0010;
    repeat (6) @(negedge clk);
    chk("trst_tlr", 32'(test_logic_reset_o), 32'h1);
    chk("trst_selects", 32'(dut_sel()), 32'h0);
  endtask

  function automatic logic [31:0] obs_word();
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < obs.size() && i < 32; i++) v[i] = obs[i];
    return v;
  endfunction

  // Monitor: after every TCK fall, wait for the DUT to register TDO, then score it.
  initial begin
    forever begin
      @(negedge tck);
      repeat (3) @(posedge clk);
      @(negedge clk);
      if (q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL sb_empty: got TCK fall with no expectation, expected one queued");
      end else begin
        mon_e = q.pop_front();
        chk("tdo", 32'(tdo_pad_o), 32'(mon_e.tdo));
        chk("tdo_oe", 32'(tdo_padoe_o), 32'(mon_e.oe));
        chk("state_strobes", 32'(dut_strb()), 32'(mon_e.strb));
        chk("selects", 32'(dut_sel()), 32'(mon_e.sel));
        chk("tdi_fwd", 32'(tdi_o), 32'(mon_e.tdi));
        if (tdo_padoe_o) obs.push_back(tdo_pad_o);
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: got no end of test, expected finish within 5ms");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail + 1);
    $fatal(1, "watchdog expired");
  end

  int r;

  initial begin
    model_reset();
    do_rst();

    // Five TMS=1 rises keep/return the TAP in Test-Logic-Reset.
    repeat (5) tck_cycle(1'b1, 1'b0);
    chk("tlr_after_5", 32'(test_logic_reset_o), 32'h1);
    chk("tlr_selects", 32'(dut_sel()), 32'h0);
    chk("tlr_oe", 32'(tdo_padoe_o), 32'h0);
    tck_cycle(1'b0, 1'b0);

    // IDCODE read-out, LSB first.
    obs.delete();
    shift_dr(32, {$urandom, $urandom});
    chk("idcode_len", 32'(obs.size()), 32'd32);
    chk("idcode_word", obs_word(), IDC);

    // DEBUG load: IR capture pattern visible on TDO, then debug chain on TDO.
    obs.delete();
    shift_ir(4'b1000);
    chk("ir_capture_len", 32'(obs.size()), 32'd4);
    chk("ir_capture_bits", obs_word(), 32'h5);
    chk("debug_sel", 32'(dut_sel()), 32'h1);
    shift_dr(16, {$urandom, $urandom});

    // BYPASS: pattern returns one TCK late behind the captured 0.
    shift_ir(4'b1111);
    obs.delete();
    shift_dr(5, 64'b0_1101);
    chk("bypass_bits", obs_word(), 32'b11010);

    shift_ir(4'b0001);
    chk("sample_sel", 32'(dut_sel()), 32'h4);
    shift_ir(4'b1001);
    chk("mbist_sel", 32'(dut_sel()), 32'h2);
    shift_ir(4'b0110);
    chk("unknown_sel", 32'(dut_sel()), 32'h0);

    // TRST during Shift-DR.
    shift_ir(4'b0000);
    tck_cycle(1'b1, 1'b0);
    tck_cycle(1'b0, 1'b0);
    tck_cycle(1'b0, 1'b0);
    tck_cycle(1'b0, 1'b1);
    tck_cycle(1'b0, 1'b0);
    do_trst();
    tck_cycle(1'b1, 1'b0);
    chk("trst_oe_next_fall", 32'(tdo_padoe_o), 32'h0);
    tck_cycle(1'b0, 1'b0);

    // Synchronous reset mid-shift.
    shift_ir(4'b1000);
    tck_cycle(1'b1, 1'b0);
    tck_cycle(1'b0, 1'b0);
    tck_cycle(1'b0, 1'b0);
    tck_cycle(1'b0, 1'b1);
    do_rst();
    tck_cycle(1'b1, 1'b0);
    tck_cycle(1'b0, 1'b0);

    // Random traffic with occasional structured scans and resets.
    for (int k = 0; k < 300; k++) begin
      r = int'($urandom_range(0, 99));
      test_mode = ($urandom & 1) != 0;
      if (r < 2) begin
        do_rst();
      end else if (r < 4) begin
        do_trst();
      end else if (r < 12 && m_st == S_RTI) begin
        shift_ir(4'($urandom_range(0, 15)));
      end else if (r < 18 && m_st == S_RTI) begin
        shift_dr(int'($urandom_range(1, 40)), {$urandom, $urandom});
      end else begin
        tck_cycle($urandom_range(0, 99) < 40, ($urandom & 1) != 0);
      end
      if (obs.size() > 256) obs.delete();
    end

    repeat (8) @(negedge clk);
    chk("sb_drain", 32'(q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
